// File: rtl/jt51_pkg.sv
// Shared jt51 definitions: noise-path widths, default LFSR seed and the
// LFSR-bit/envelope to signed noise sample mapping.
package jt51_pkg;

  localparam int unsigned NFRQ_W     = 5;
  localparam int unsigned EG_W       = 10;
  localparam int unsigned OUT_W      = 11;
  localparam int unsigned LFSR_W     = 17;
  localparam int unsigned NOISE_INIT = 14220;

  typedef logic [OUT_W-1:0] noise_t;

  // Loudness is the inverted attenuation; a 0 bit gives the ones' complement
  // of the positive sample, so the two levels are +amp and -amp-1.
  function automatic noise_t noise_map(input logic       nbit,
                                       input logic       ne,
                                       input logic [EG_W-1:0] eg);
    logic [EG_W-1:0] amp;
    noise_t          pos;
    amp = ~eg;
    pos = {1'b0, amp};
    if (!ne)
      return '0;
    return nbit ? pos : ~pos;
  endfunction

endpackage

// File: rtl/jt51_noise_lfsr.sv
// 17-bit noise LFSR: shifts left once per base pulse, feedback ~(b16^b13),
// output is the MSB.
module jt51_noise_lfsr
  import jt51_pkg::*;
#(
  parameter int unsigned init = NOISE_INIT
) (
  input  logic rst,
  input  logic clk,
  input  logic base,
  output logic out
);

  localparam logic [LFSR_W-1:0] SEED = init[LFSR_W-1:0];

  logic [LFSR_W-1:0] bb;

  always_ff @(posedge clk) begin
    if (rst)
      bb <= SEED;
    else if (base)
      bb <= {bb[LFSR_W-2:0], ~(bb[16] ^ bb[13])};
  end

  assign out = bb[LFSR_W-1];

endmodule

// File: rtl/jt51_noise_gen.sv
// Noise generator: period counter on the sample strobe, LFSR advance, and a
// registered signed noise sample captured on the op31 slot.
module jt51_noise_gen
  import jt51_pkg::*;
#(
  parameter int unsigned INIT = NOISE_INIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              zero,
  input  logic              op31,
  input  logic [NFRQ_W-1:0] nfrq,
  input  logic              ne,
  input  logic [EG_W-1:0]   eg,
  output logic [OUT_W-1:0]  out_noise,
  output logic              out_valid,
  output logic              lfsr_bit
);

  logic [NFRQ_W-1:0] cnt;
  logic              base;
  logic              base_cen;
  logic              rst;

  assign rst = ~rst_n;
  // base is held across cen=0 cycles; gating it here makes the LFSR step
  // exactly once, on the first enabled cycle after the pulse is raised.
  assign base_cen = base & cen;

  jt51_noise_lfsr #(
    .init(INIT)
  ) u_lfsr (
    .rst (rst),
    .clk (clk),
    .base(base_cen),
    .out (lfsr_bit)
  );

  // >= rather than == so lowering the threshold below cnt fires at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      base <= 1'b0;
    end else if (cen) begin
      base <= 1'b0;
      if (zero) begin
        if (cnt >= ~nfrq) begin
          cnt  <= '0;
          base <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_noise <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= cen & op31;
      if (cen && op31)
        out_noise <= noise_map(lfsr_bit, ne, eg);
    end
  end

endmodule

// File: tb/tb_jt51_noise_gen.sv
// Randomized scoreboard bench for jt51_noise_gen against a period/sequence
// reference model.
module tb_jt51_noise_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        zero = 1'b0;
  logic        op31 = 1'b0;
  logic [4:0]  nfrq = '0;
  logic        ne = 1'b1;
  logic [9:0]  eg = '0;
  logic [10:0] out_noise;
  logic        out_valid;
  logic        lfsr_bit;

  always #5 clk = ~clk;

  jt51_noise_gen #(.INIT(14220)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .zero     (zero),
    .op31     (op31),
    .nfrq     (nfrq),
    .ne       (ne),
    .eg       (eg),
    .out_noise(out_noise),
    .out_valid(out_valid),
    .lfsr_bit (lfsr_bit)
  );

  int ncheck = 0;
  int nfail  = 0;
  int exp_q[$];
  bit seq[4096];
  int idx   = 0;
  bit pend  = 0;
  int since = 0;
  int out_m = 0;
  bit mon_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ncheck++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int expect_out(input bit b, input bit n_e, input int e);
    int amp;
    amp = 1023 - e;
    if (!n_e) return 0;
    return b ? amp : (2048 - amp - 1);
  endfunction

  // Noise period is 32-nfrq strobes; the LFSR steps on the enabled cycle
  // after the strobe that completes a period.
  task automatic model_edge();
    if (!rst_n) begin
      since = 0; pend = 0; idx = 0; out_m = 0;
      exp_q.delete();
    end else if (cen) begin
      if (op31) begin
        out_m = expect_out(seq[idx], ne, int'(eg));
        exp_q.push_back(out_m);
      end
      if (pend) begin
        idx++;
        pend = 0;
      end
      if (zero) begin
        since++;
        if (since >= 32 - int'(nfrq)) begin
          since = 0;
          pend  = 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit z, input bit o,
                     input int nf, input bit n_e, input int e);
    @(negedge clk);
    rst_n = r; cen = c; zero = z; op31 = o;
    nfrq = nf[4:0]; ne = n_e; eg = e[9:0];
    @(posedge clk);
    model_edge();
  endtask

  function automatic int pick_eg();
    int r;
    r = $urandom_range(3);
    if (r == 0) return 0;
    if (r == 1) return 1023;
    return $urandom_range(1023);
  endfunction

  task automatic frames(input int n, input int nf, input bit n_e,
                        input int op_slot, input int cen_pct);
    int slot;
    bit c;
    for (int f = 0; f < n; f++) begin
      slot = 0;
      while (slot < 32) begin
        c = ($urandom_range(99) < cen_pct);
        cyc(1, c, slot == 0, slot == op_slot, nf, n_e, pick_eg());
        if (c) slot++;
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 1, $urandom_range(1), $urandom_range(1), $urandom_range(31), 1, pick_eg());
  endtask

  // Monitor: out_valid must track scoreboard occupancy; the sample and
  // LFSR bit are compared every cycle so holds and resets are covered too.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("out_valid", int'(out_valid), (exp_q.size() != 0) ? 1 : 0);
        if (out_valid && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_noise_valid", int'(out_noise), e);
        end else begin
          chk("out_noise_hold", int'(out_noise), out_m);
        end
        chk("lfsr_bit", int'(lfsr_bit), int'(seq[idx]));
      end
    end
  end

  initial begin
    int s, fb;
    s = 14220;
    for (int i = 0; i < 4096; i++) begin
      seq[i] = s[16];
      fb = ~((s >> 16) ^ (s >> 13)) & 1;
      s = ((s << 1) | fb) & 'h1FFFF;
    end

    do_reset(2);
    mon_en = 1;
    @(negedge clk);
    chk("reset_out_noise", int'(out_noise), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_lfsr_bit", int'(lfsr_bit), 0);

    // Fastest period, then slowest period over two full periods.
    frames(6, 31, 1, 31, 100);
    frames(70, 0, 1, 31, 100);

    // Raising nfrq from 0 to 31 with a partial count pending.
    do_reset(1);
    frames(20, 0, 1, 31, 100);
    frames(3, 31, 1, 31, 100);

    // base and op31 in the same cycle.
    frames(6, 31, 1, 1, 100);

    // Noise disabled: sample forced to zero, counter/LFSR keep going.
    frames(5, 31, 0, 31, 100);

    // Random nfrq with a sparse clock enable.
    for (int i = 0; i < 40; i++)
      frames(1, $urandom_range(31), $urandom_range(3) != 0, $urandom_range(31), 50);

    // Clock enable held low while strobes toggle.
    for (int i = 0; i < 100; i++)
      cyc(1, 0, $urandom_range(1), $urandom_range(1), $urandom_range(31), 1, pick_eg());

    // Reset in the middle of a period restarts count and sequence.
    frames(3, 29, 1, 31, 100);
    for (int i = 0; i < 10; i++)
      cyc(1, 1, i == 0, i == 5, 29, 1, pick_eg());
    do_reset(1);
    frames(8, 30, 1, 7, 100);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule

// File: doc/jt51_noise_gen.md
JT51_NOISE_GEN -- requirements
Module: jt51_noise_gen

Interface
REQ-001 Parameter: INIT, 14220, 17-bit seed loaded into the noise LFSR on reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-004 cen  in  1  clock enable; all state, including the LFSR, SHALL hold when cen=0.
REQ-005 zero  in  1  sample strobe, high for one cen-qualified cycle per 32-slot sample period.
REQ-006 op31  in  1  slot strobe marking the channel-7/op-4 slot where noise is consumed.
REQ-007 nfrq  in  5  noise frequency register value.
REQ-008 ne  in  1  noise enable register bit.
REQ-009 eg  in  10  envelope attenuation for the noise slot; 0 = loudest.
REQ-010 out_noise  out  11  signed two's-complement noise sample.
REQ-011 out_valid  out  1  one-cycle pulse: out_noise updated.
REQ-012 lfsr_bit  out  1  current LFSR output bit, for debug and test.

Function
REQ-013 Update event: cen=1 on a rising edge; nothing else SHALL change state.
REQ-014 5-bit period counter cnt: on update with zero=1, if cnt >= ~nfrq, cnt SHALL go to 0 and base SHALL be asserted; otherwise cnt SHALL increment.
REQ-015 Noise period SHALL be (32 - nfrq) zero strobes: nfrq=31 gives every strobe, nfrq=0 gives every 32nd.
REQ-016 The >= compare SHALL ensure that lowering ~nfrq below the current cnt triggers base on the next zero strobe, with no 32-step wrap.
REQ-017 base SHALL be a registered one-cycle pulse, gated with cen, driving the LFSR advance input.
REQ-018 LFSR SHALL advance exactly once per base pulse.
REQ-019 LFSR: 17-bit, shift left, feedback ~(b16 ^ b13), output b16.
REQ-020 On update with op31=1, out_noise SHALL be registered and out_valid SHALL pulse on the following cycle (latency 1).
REQ-021 Amplitude amp = ~eg (10 bits).
REQ-022 With lfsr_bit=1, out_noise = {0, amp}.
REQ-023 With lfsr_bit=0, out_noise = ~{0, amp} (ones' complement, -amp-1).
REQ-024 With ne=0, out_noise SHALL be 0, while out_valid still pulses and cnt and the LFSR keep running.
REQ-025 If base and op31 coincide, out_noise SHALL use the pre-advance LFSR bit.
REQ-026 eg, ne and lfsr_bit SHALL be sampled only on the op31 update; out_noise SHALL hold between op31 updates.
REQ-027 nfrq changes SHALL take effect at the next zero strobe.

Reset
REQ-028 rst_n=0 at a rising edge, regardless of cen, SHALL set: cnt=0, base=0, LFSR=INIT[16:0], out_noise=0, out_valid=0.
REQ-029 Reset mid-period SHALL discard the partial count; the LFSR sequence SHALL restart from INIT.

Structure
REQ-030 The shared jt51 package SHALL hold: noise widths (NFRQ_W=5, EG_W=10, OUT_W=11) and the default seed 14220.
REQ-031 The existing jt51_noise_lfsr SHALL be instantiated as the single sub-module, with init=INIT, rst=~rst_n and base=base pulse.
REQ-032 cen SHALL be folded into the base pulse.
REQ-033 The counter and output register SHALL live in jt51_noise_gen.
REQ-034 The block SHALL contain no combinational path from inputs to outputs.

Verification
REQ-035 Reset hold: rst_n=0 for 2 cycles with cen=1 -> out_noise=0x000, out_valid=0, lfsr_bit=0.
REQ-036 LFSR sequence: nfrq=31, zero every 32 cycles -> base on every strobe; lfsr_bit over the first 4 base pulses = 0,0,0,1 (bits 16..13 of 0x0378C).
REQ-037 Slowest period: nfrq=0 -> exactly one base per 32 zero strobes; cnt reaches 31 before clearing.
REQ-038 Output mapping, ne=1:
  - eg=0x000, lfsr_bit=0 -> out_noise=0x400 (-1024);
  - eg=0x000, lfsr_bit=1 -> 0x3FF;
  - eg=0x3FF -> 0x7FF or 0x000;
  - out_valid one cycle after op31.
REQ-039 Control edge cases:
  - ne=0 -> out_noise=0 with out_valid still pulsing;
  - nfrq changed 0->31 while cnt=20 -> base on the next zero strobe, cnt=0;
  - base and op31 in the same cycle -> pre-advance bit used.
REQ-040 cen=0 for 100 cycles with zero and op31 toggling -> cnt, LFSR, out_noise unchanged and no out_valid.
